// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and request type for the register-file write-back path.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  // Wide enough for any starvation bound in 1..15.
  localparam int WAIT_W     = 4;

  // One write-back request: destination register and the value to write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// One-entry hold slot for a write-back port.
//
// Handshake: a request transfers on a posedge where valid_i && ready_o.
// ready_o is high when the slot is empty or is being granted this cycle,
// so a port can refill its slot on the same edge the old entry leaves.
// ready_o is forced low while rst is high.
module wb_hold_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  input  wb_req_t req_i,
  input  logic    grant_i,
  output logic    ready_o,
  output logic    accept_o,
  output logic    hold_v_o,
  output wb_req_t hold_o
);

  logic    hold_v_q, hold_v_d;
  wb_req_t hold_q, hold_d;

  assign ready_o  = !rst && (!hold_v_q || grant_i);
  assign accept_o = valid_i && ready_o;
  assign hold_v_o = hold_v_q;
  assign hold_o   = hold_q;

  // Next slot contents: a new accept overrides the grant-driven clear.
  always_comb begin
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    if (accept_o) begin
      hold_v_d = 1'b1;
      hold_d   = req_i;
    end else if (grant_i) begin
      hold_v_d = 1'b0;
    end
  end

  // Slot registers; reset discards any held request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Port A has fixed priority; port B is protected by a bounded wait counter.
// Same-register entries are issued oldest first.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_reg,
  input  logic [REG_DATA_W-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_reg,
  input  logic [REG_DATA_W-1:0] b_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [REG_DATA_W-1:0] write_data,
  output logic                  busy
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic    a_hold_v, b_hold_v, a_accept, b_accept, grant_a, grant_b;
  wb_req_t a_hold, b_hold, win_req;

  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  older_q, older_d;   // 1: B entry is older than A
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [REG_DATA_W-1:0] write_data_q, write_data_d;

  wb_hold_slot u_slot_a (
    .clk     (clk),
    .rst     (rst),
    .valid_i (a_valid),
    .req_i   ('{reg_addr: a_reg, data: a_data}),
    .grant_i (grant_a),
    .ready_o (a_ready),
    .accept_o(a_accept),
    .hold_v_o(a_hold_v),
    .hold_o  (a_hold)
  );

  wb_hold_slot u_slot_b (
    .clk     (clk),
    .rst     (rst),
    .valid_i (b_valid),
    .req_i   ('{reg_addr: b_reg, data: b_data}),
    .grant_i (grant_b),
    .ready_o (b_ready),
    .accept_o(b_accept),
    .hold_v_o(b_hold_v),
    .hold_o  (b_hold)
  );

  // Pick the winner among held entries: ordering beats priority, the wait
  // bound beats A's priority.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_hold_v && b_hold_v) begin
      if (a_hold.reg_addr == b_hold.reg_addr) begin
        grant_a = !older_q;
        grant_b = older_q;
      end else if (wait_cnt_q == MAX_WAIT_C) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = a_hold_v;
      grant_b = b_hold_v;
    end
  end

  // Next wait count, age flag and output register values.
  always_comb begin
    wait_cnt_d   = '0;
    older_d      = 1'b0;
    win_req      = grant_b ? b_hold : a_hold;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (b_hold_v && !grant_b)
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;

    // Age only matters while both slots will be occupied; a freshly
    // accepted entry is younger than one that stayed, A wins a tie.
    if ((a_accept || (a_hold_v && !grant_a)) && (b_accept || (b_hold_v && !grant_b))) begin
      if (a_accept && !b_accept)      older_d = 1'b1;
      else if (b_accept)              older_d = 1'b0;
      else                            older_d = older_q;
    end

    // Register 0 is never written, but the cycle is still consumed.
    if (grant_a || grant_b) begin
      reg_write_d  = (win_req.reg_addr != '0);
      write_reg_d  = win_req.reg_addr;
      write_data_d = win_req.data;
    end
  end

  // Arbiter state and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      older_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      older_q      <= older_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign busy       = a_hold_v || b_hold_v || reg_write_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a timestamp-based model.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int VW = 41;  // {a_ready, b_ready, reg_write, write_reg, write_data, busy}

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_reg, b_reg, write_reg;
  logic [31:0] a_data, b_data, write_data;
  logic        reg_write, busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .busy      (busy)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: each held request carries the cycle it was accepted.
  bit          ma_v, mb_v;
  logic [4:0]  ma_reg, mb_reg;
  logic [31:0] ma_data, mb_data;
  int          ma_t, mb_t, m_loss;
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  logic [VW-1:0] obs_vec, exp_vec;
  logic          obs_ar, obs_br, exp_ar, exp_br;
  bit            acc_a, acc_b;
  logic [36:0]   exp_q[$];
  logic [31:0]   rf [32];

  // ---------------- driver + model step ----------------
  // Drives one cycle of inputs at the negedge, advances the model across the
  // posedge and captures observed/expected vectors at the following negedge.
  task automatic step(input logic r,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd);
    int win;
    rst = r; a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    #1;
    obs_ar = a_ready;
    obs_br = b_ready;
    win = 0;
    if (ma_v && mb_v) begin
      if (ma_reg == mb_reg) win = (ma_t <= mb_t) ? 1 : 2;
      else                  win = (m_loss >= MAX_WAIT) ? 2 : 1;
    end else if (ma_v) win = 1;
    else if (mb_v)     win = 2;
    exp_ar = !r && (!ma_v || win == 1);
    exp_br = !r && (!mb_v || win == 2);
    acc_a = av && exp_ar;
    acc_b = bv && exp_br;
    if (r) begin
      ma_v = 0; mb_v = 0; m_loss = 0; m_rw = 0; m_wr = '0; m_wd = '0;
    end else begin
      if (mb_v && win != 2) m_loss = (m_loss < MAX_WAIT) ? m_loss + 1 : MAX_WAIT;
      else                  m_loss = 0;
      if (win == 1) begin
        m_rw = (ma_reg != 0); m_wr = ma_reg; m_wd = ma_data; ma_v = 0;
      end else if (win == 2) begin
        m_rw = (mb_reg != 0); m_wr = mb_reg; m_wd = mb_data; mb_v = 0;
      end else begin
        m_rw = 0;
      end
      if (acc_a) begin ma_v = 1; ma_reg = ar; ma_data = ad; ma_t = cyc; end
      if (acc_b) begin mb_v = 1; mb_reg = br; mb_data = bd; mb_t = cyc; end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    obs_vec = {obs_ar, obs_br, reg_write, write_reg, write_data, busy};
    exp_vec = {exp_ar, exp_br, m_rw, m_wr, m_wd, ma_v | mb_v | m_rw};
    if (reg_write === 1'b1) rf[write_reg] = write_data;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({obs_ar, obs_br, reg_write, write_reg, write_data, busy} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", obs_vec);
    else n_pass++;
    idle();
    n_checks++;
    if ({obs_ar, obs_br} !== 2'b11) $display("FAIL reset_ready got=%b exp=11", {obs_ar, obs_br});
    else n_pass++;
  endtask

  task automatic test_a_only();
    step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (obs_ar !== 1'b1 || reg_write !== 1'b0)
      $display("FAIL a_only_accept ready=%b rw=%b exp ready=1 rw=0", obs_ar, reg_write);
    else n_pass++;
    idle();
    n_checks++;
    if ({reg_write, write_reg, write_data} !== {1'b1, 5'd5, 32'h1234} || obs_ar !== 1'b1)
      $display("FAIL a_only_write got=%b/%0d/%h ready=%b exp=1/5/1234 ready=1",
               reg_write, write_reg, write_data, obs_ar);
    else n_pass++;
    idle();
    n_checks++;
    if (reg_write !== 1'b0) $display("FAIL a_only_single got rw=%b exp=0", reg_write);
    else n_pass++;
    n_checks++;
    if (obs_vec !== exp_vec) $display("FAIL a_only_model got=%h exp=%h", obs_vec, exp_vec);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first_c, last_c, n_w;
    logic [31:0] d;
    first_c = -1; last_c = -1; n_w = 0;
    for (int k = 8; k <= 15; k++) begin
      d = $urandom;
      exp_q.push_back({5'(k), d});
      step(1'b0, 1'b1, 5'(k), d, 1'b0, 5'd0, 32'd0);
      n_checks++;
      if (obs_ar !== 1'b1 || obs_vec !== exp_vec)
        $display("FAIL b2b_stream k=%0d got=%h exp=%h", k, obs_vec, exp_vec);
      else n_pass++;
      if (reg_write === 1'b1) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc; n_w++;
        n_checks++;
        if ({write_reg, write_data} !== exp_q[0])
          $display("FAIL b2b_order got=%h exp=%h", {write_reg, write_data}, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      if (reg_write === 1'b1) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc; n_w++;
        n_checks++;
        if (exp_q.size() == 0 || {write_reg, write_data} !== exp_q[0])
          $display("FAIL b2b_order got=%h", {write_reg, write_data});
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (n_w != 8 || last_c - first_c != 7)
      $display("FAIL b2b_bubbles writes=%0d span=%0d exp writes=8 span=7", n_w, last_c - first_c);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_contention();
    logic [31:0] ad, bd;
    int last_b, b_cnt;
    ad = $urandom; bd = $urandom; last_b = -1; b_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, 5'd1, ad, 1'b1, 5'd2, bd);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL contention_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      else n_pass++;
      if (acc_a) ad = $urandom;
      if (acc_b) bd = $urandom;
      if (reg_write === 1'b1 && write_reg === 5'd2) begin
        b_cnt++;
        if (last_b >= 0) begin
          n_checks++;
          if (cyc - last_b != MAX_WAIT + 1)
            $display("FAIL contention_gap got=%0d exp=%0d", cyc - last_b, MAX_WAIT + 1);
          else n_pass++;
        end
        last_b = cyc;
      end
    end
    n_checks++;
    if (b_cnt != 11) $display("FAIL contention_b_count got=%0d exp=11", b_cnt);
    else n_pass++;
    for (int i = 0; i < 4; i++) idle();
  endtask

  task automatic test_same_reg();
    exp_q.push_back({5'd3, 32'h33});
    exp_q.push_back({5'd7, 32'hB});
    exp_q.push_back({5'd7, 32'hA});
    step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hB);
    step(1'b0, 1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (obs_ar !== 1'b1 || obs_vec !== exp_vec) $display("FAIL same_reg_accept got=%h exp=%h", obs_vec, exp_vec);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (reg_write === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || {write_reg, write_data} !== exp_q[0])
          $display("FAIL same_reg_order got=%h", {write_reg, write_data});
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      idle();
    end
    n_checks++;
    if (exp_q.size() != 0 || rf[7] !== 32'hA)
      $display("FAIL same_reg_final left=%0d r7=%h exp left=0 r7=a", exp_q.size(), rf[7]);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reg0();
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if (obs_ar !== 1'b1) $display("FAIL reg0_handshake got ready=%b exp=1", obs_ar);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (reg_write !== 1'b0 || obs_vec !== exp_vec)
        $display("FAIL reg0_no_write i=%0d rw=%b got=%h exp=%h", i, reg_write, obs_vec, exp_vec);
      else n_pass++;
      idle();
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b0, 1'b1, 5'd20, 32'h2020, 1'b1, 5'd21, 32'h2121);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n_checks++;
    if ({obs_ar, obs_br, reg_write, write_reg, write_data, busy} !== '0)
      $display("FAIL midreset_outputs got=%h exp=0", {obs_ar, obs_br, reg_write, write_reg, write_data, busy});
    else n_pass++;
    idle();
    n_checks++;
    if ({obs_ar, obs_br} !== 2'b11) $display("FAIL midreset_ready got=%b exp=11", {obs_ar, obs_br});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (reg_write !== 1'b0 || busy !== 1'b0)
        $display("FAIL midreset_no_write rw=%b busy=%b exp=0/0", reg_write, busy);
      else n_pass++;
      idle();
    end
  endtask

  task automatic test_random();
    logic pav, pbv, r;
    logic [4:0] par, pbr;
    logic [31:0] pad, pbd;
    pav = 0; pbv = 0; par = '0; pbr = '0; pad = '0; pbd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pav && $urandom_range(0, 2) != 0) begin
        pav = 1; par = 5'($urandom_range(0, 3)); pad = $urandom;
      end
      if (!pbv && $urandom_range(0, 1) != 0) begin
        pbv = 1; pbr = 5'($urandom_range(0, 3)); pbd = $urandom;
      end
      r = ($urandom_range(0, 60) == 0);
      step(r, pav, par, pad, pbv, pbr, pbd);
      n_checks++;
      if (obs_vec !== exp_vec) $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      else n_pass++;
      if (acc_a) pav = 0;
      if (acc_b) pbv = 0;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; a_valid = 0; b_valid = 0; a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    ma_v = 0; mb_v = 0; ma_t = 0; mb_t = 0; m_loss = 0; m_rw = 0; m_wr = '0; m_wd = '0;
    ma_reg = '0; mb_reg = '0; ma_data = '0; mb_data = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    @(negedge clk);
    test_reset();
    test_a_only();
    test_back_to_back();
    test_contention();
    test_same_reg();
    test_reg0();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. It accepts write requests from two producers over valid/ready handshakes: port A is the ALU/main pipeline write-back, and port B is the multi-cycle unit or load return. It buffers one request per port and issues at most one registered write per cycle to the register file's `reg_write`/`write_reg`/`write_data` inputs. Port A has fixed priority, and a bounded starvation guard protects port B.

## Interface
- `MAX_WAIT`, 4: cycles a held B request may lose arbitration before it is forced to win (1..15).
- `clk` in 1: system clock. All state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `a_valid` in 1: port A request valid.
- `a_ready` out 1: port A can accept this cycle.
- `a_reg` in 5: port A destination register.
- `a_data` in 32: port A write data.
- `b_valid` in 1: port B request valid.
- `b_ready` out 1: port B can accept this cycle.
- `b_reg` in 5: port B destination register.
- `b_data` in 32: port B write data.
- `reg_write` out 1: register file write enable (registered).
- `write_reg` out 5: register file write address (registered).
- `write_data` out 32: register file write data (registered).
- `busy` out 1: either hold slot occupied or `reg_write` high.

## Operation
- Each port has a one-entry hold slot: `hold_v`, `hold_reg`, `hold_data`.
- Handshake: a transfer occurs on a posedge where `valid && ready`.
- `x_ready = !x_hold_v || x_grant`. This is combinational from state and the same-cycle grant, so back-to-back requests run at 1 per cycle per port.
- Producers must hold `valid`, `reg` and `data` stable until ready. The arbiter never drops an accepted request.
- Arbitration each cycle, over held entries only:
  - Only A held: A wins.
  - Only B held: B wins.
  - Both held: A wins, unless `wait_cnt == MAX_WAIT`, in which case B wins.
- `wait_cnt`:
  - Increments (saturating at `MAX_WAIT`) on cycles where B is held and loses.
  - Clears to 0 when B is granted or B is not held.
- Same-register ordering: if both slots are held with equal `hold_reg`, the entry accepted earlier wins regardless of priority. A 1-bit `older` flag tracks this. If both were accepted on the same edge, A is older.
- Granted slot: `hold_v` clears, unless refilled on the same edge. The output registers load `{1, hold_reg, hold_data}`.
- No grant: `reg_write` loads 0. `write_reg`/`write_data` hold their previous values.
- Register 0: requests with `reg == 0` are accepted and arbitrated normally. The resulting output cycle drives `reg_write = 0`, preserving `register_file[0] = 0`.
- Reset:
  - All `hold_v`, `wait_cnt` and `older` are cleared.
  - `reg_write`, `write_reg` and `write_data` are 0; `busy` is 0.
  - `a_ready` and `b_ready` are 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards held requests silently. No write is issued for them.
- `rst` high: `a_ready = b_ready = 0`. No transfers are accepted.

## Timing
- Accept edge E: the request is in the hold slot after E.
- Earliest grant is the cycle after E. Output registers load at E+1, so `reg_write` is high during cycle E+1..E+2.
- The register file commits at posedge E+2.
- Minimum latency is 2 edges from handshake to commit. Throughput is 1 write per cycle total.
- Worst-case B wait while held under continuous A traffic: `MAX_WAIT` + 1 cycles.
- A simultaneous refill and grant of the same slot on one edge is legal and must not lose either request.
- Downstream consumers must not read a destination before its commit edge. Bypassing is outside this block.

## Structure
- The shared package holds the `REG_ADDR_W = 5` and `REG_DATA_W = 32` constants and the `wb_req_t` struct `{reg, data}`. The register file uses the same widths.
- The hold slot is natural as one sub-module, `wb_hold_slot`, instantiated twice. It contains the valid/reg/data registers and the ready logic.
- Arbitration, `wait_cnt`, `older` and the output registers stay in the top.

## Test plan
- **A only.** A writes r5=0x1234 at edge 1. Expect `reg_write=1`, `write_reg=5`, `write_data=0x1234` during cycle 2 only, and `a_ready` stays 1.
- **Contention.** A and B are both valid every cycle with `MAX_WAIT=4`, using distinct registers (A→r1, B→r2). Expect B granted exactly once per 5 output cycles, and `wait_cnt` never exceeds 4.
- **Same-register ordering.** B sends r7=0xB first. One cycle later, A sends r7=0xA while B is still held. Expect the output order 0xB then 0xA, so the final r7 is 0xA.
- **Register 0.** A sends r0=0xFFFF_FFFF. Expect the handshake to complete and `reg_write` to stay 0 for all cycles.
- **Back-pressure.** A streams 8 requests r8..r15 with B idle. Expect 8 consecutive `reg_write` pulses, in order, with no bubbles.
- **Reset mid-flight.** Both slots are held and `rst` is asserted for one cycle. Expect no write from the held entries, all outputs 0, and both ready signals 1 on the cycle after reset deasserts.
